// File: rtl/comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
//   state_t   : controller state encoding (IDLE / SCAN / DONE)
//   RES_*     : one-hot result codes, packed as {aeb, agb, alb}
//   res_code  : packs a one-hot result from individual eq/gt/lt flags
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

  function automatic logic [2:0] res_code(input logic eq, input logic gt, input logic lt);
    return {eq, gt, lt};
  endfunction

endpackage

// File: rtl/comp_bit_stage.sv
// Combinational 1-bit comparator stage.
//   a, b : the single bits being compared
//   eq   : a == b
//   gt   : a > b  (a=1, b=0)
//   lt   : a < b  (a=0, b=1)
module comp_bit_stage (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = ~(a ^ b);
  assign gt = a & ~b;
  assign lt = ~a & b;

endmodule

// File: rtl/comp_serial_ctrl.sv
// Bit-serial magnitude compare controller. Captures two WIDTH-bit operands
// on an accepted start, walks them MSB first through a single 1-bit
// comparator stage, and reports a one-hot aeb/agb/alb result with a done
// pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : compare request, honoured only in IDLE
//   a_in, b_in : operands, captured on the accepted start
//   busy       : high while scanning
//   done       : one-cycle pulse, results valid
//   aeb/agb/alb: one-hot result, forced to 0 while busy, held until next start
//   nbits      : bit positions examined by the last (or current) compare
module comp_serial_ctrl
  import comp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a_in,
  input  logic [WIDTH-1:0]           b_in,
  output logic                       busy,
  output logic                       done,
  output logic                       aeb,
  output logic                       agb,
  output logic                       alb,
  output logic [$clog2(WIDTH+1)-1:0] nbits
);

  localparam int NW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]   idx_reg;
  logic [NW-1:0]   nbits_reg;
  logic [2:0]      res_reg;
  logic            diff_seen_reg;

  logic bit_eq, bit_gt, bit_lt;
  logic first_diff;
  logic last_bit;

  comp_bit_stage u_stage (
    .a  (a_reg[idx_reg]),
    .b  (b_reg[idx_reg]),
    .eq (bit_eq),
    .gt (bit_gt),
    .lt (bit_lt)
  );

  // Only the MSB-most difference is ever recorded.
  assign first_diff = ~bit_eq & ~diff_seen_reg;
  assign last_bit   = (idx_reg == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = SCAN;
      SCAN: if ((EARLY_EXIT && first_diff) || last_bit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand, index, counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      idx_reg       <= '0;
      nbits_reg     <= '0;
      res_reg       <= RES_NONE;
      diff_seen_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg         <= a_in;
            b_reg         <= b_in;
            idx_reg       <= IW'(WIDTH - 1);
            nbits_reg     <= '0;
            res_reg       <= RES_NONE;
            diff_seen_reg <= 1'b0;
          end
        end
        SCAN: begin
          if (nbits_reg != NW'(WIDTH)) nbits_reg <= nbits_reg + 1'b1;
          if (first_diff) begin
            res_reg       <= res_code(1'b0, bit_gt, bit_lt);
            diff_seen_reg <= 1'b1;
          end else if (last_bit && !diff_seen_reg) begin
            // Reached bit 0 with no difference anywhere: operands equal.
            res_reg <= RES_EQ;
          end
          if (state_next == SCAN && !last_bit) idx_reg <= idx_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy  = (state_reg == SCAN);
    done  = (state_reg == DONE);
    nbits = nbits_reg;
    {aeb, agb, alb} = busy ? RES_NONE : res_reg;
  end

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Directed bench for comp_serial_ctrl. Two instances share the stimulus:
// dut_ee (EARLY_EXIT=1) and dut_full (EARLY_EXIT=0, always 8 scan cycles).
// Latency is counted as the number of clock edges after the accepting edge
// until done is observed (#1 after the edge); that equals k, so done is
// sampled high at edge k+1.
module tb_comp_serial_ctrl;
  import comp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] a_in, b_in;

  logic       e_busy, e_done, e_aeb, e_agb, e_alb;
  logic [3:0] e_nbits;
  logic       f_busy, f_done, f_aeb, f_agb, f_alb;
  logic [3:0] f_nbits;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  comp_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(e_busy), .done(e_done), .aeb(e_aeb), .agb(e_agb), .alb(e_alb),
    .nbits(e_nbits)
  );

  comp_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(f_busy), .done(f_done), .aeb(f_aeb), .agb(f_agb), .alb(f_alb),
    .nbits(f_nbits)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;
    int         k;   // early-exit scan length, also the expected nbits
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one compare and observe both DUTs for a fixed window.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                         output logic [2:0] r1, output int n1, output int lat1, output int cnt1,
                         output logic [2:0] r0, output int n0, output int lat0, output int cnt0,
                         output int busy_bad);
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    a_in = ~a; b_in = ~b;   // must not affect the captured operands
    lat1 = -1; lat0 = -1; cnt1 = 0; cnt0 = 0; busy_bad = 0;
    r1 = 3'b111; r0 = 3'b111; n1 = -1; n0 = -1;
    for (int c = 0; c <= 11; c++) begin
      if (e_done) begin
        cnt1++;
        if (lat1 < 0) begin
          lat1 = c; r1 = {e_aeb, e_agb, e_alb}; n1 = int'(e_nbits);
        end
      end else if (lat1 < 0) begin
        if (!e_busy || {e_aeb, e_agb, e_alb} != 3'b000) busy_bad++;
      end
      if (f_done) begin
        cnt0++;
        if (lat0 < 0) begin
          lat0 = c; r0 = {f_aeb, f_agb, f_alb}; n0 = int'(f_nbits);
        end
      end
      tick();
    end
  endtask

  initial begin
    logic [2:0] r1, r0;
    int n1, n0, lat1, lat0, cnt1, cnt0, bb;
    int last_done, pulses, prev;

    vecs[0]  = '{8'hA5, 8'hA5, RES_EQ, 8};
    vecs[1]  = '{8'h80, 8'h7F, RES_GT, 1};
    vecs[2]  = '{8'h12, 8'h13, RES_LT, 8};
    vecs[3]  = '{8'h01, 8'h01, RES_EQ, 8};
    vecs[4]  = '{8'hFF, 8'h00, RES_GT, 1};
    vecs[5]  = '{8'h00, 8'h00, RES_EQ, 8};
    vecs[6]  = '{8'h40, 8'h50, RES_LT, 4};  // first difference at bit 4
    vecs[7]  = '{8'h7F, 8'h80, RES_LT, 1};
    vecs[8]  = '{8'h03, 8'h02, RES_GT, 8};
    vecs[9]  = '{8'hC0, 8'h80, RES_GT, 2};
    vecs[10] = '{8'h5A, 8'h4A, RES_GT, 4};
    vecs[11] = '{8'h00, 8'h01, RES_LT, 8};

    rst_n = 1'b0; start = 1'b0; a_in = 8'h00; b_in = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_busy",  int'(e_busy), 0);
    chk("reset_done",  int'(e_done), 0);
    chk("reset_res",   int'({e_aeb, e_agb, e_alb}), 0);
    chk("reset_nbits", int'(e_nbits), 0);
    tick();

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_cmp(vecs[i].a, vecs[i].b, r1, n1, lat1, cnt1, r0, n0, lat0, cnt0, bb);
      $display("vec %0d: a=%02h b=%02h ee:res=%03b nbits=%0d lat=%0d full:res=%03b nbits=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, r1, n1, lat1, r0, n0, lat0);
      chk($sformatf("v%0d_ee_res", i),   int'(r1), int'(vecs[i].res));
      chk($sformatf("v%0d_ee_nbits", i), n1, vecs[i].k);
      chk($sformatf("v%0d_ee_lat", i),   lat1, vecs[i].k);
      chk($sformatf("v%0d_ee_pulses", i), cnt1, 1);
      chk($sformatf("v%0d_ee_busy", i),  bb, 0);
      chk($sformatf("v%0d_full_res", i), int'(r0), int'(vecs[i].res));
      chk($sformatf("v%0d_full_nbits", i), n0, 8);
      chk($sformatf("v%0d_full_lat", i), lat0, 8);
      chk($sformatf("v%0d_full_pulses", i), cnt0, 1);
      chk($sformatf("v%0d_ee_hold", i),  int'({e_aeb, e_agb, e_alb}), int'(vecs[i].res));
    end

    // Results held for 5 idle cycles after 12 vs 13
    run_cmp(8'h12, 8'h13, r1, n1, lat1, cnt1, r0, n0, lat0, cnt0, bb);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d_res", c),   int'({e_aeb, e_agb, e_alb}), int'(RES_LT));
      chk($sformatf("hold%0d_nbits", c), int'(e_nbits), 8);
      tick();
    end
    $display("seq hold: done");

    // Start while busy (scan cycle 3) and in DONE is ignored
    a_in = 8'h01; b_in = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    lat1 = -1;
    for (int c = 0; c <= 10 && lat1 < 0; c++) begin
      if (c == 3) begin start = 1'b1; a_in = 8'hFF; b_in = 8'h00; end
      if (c == 4) start = 1'b0;
      if (e_done) begin
        lat1 = c; r1 = {e_aeb, e_agb, e_alb}; n1 = int'(e_nbits);
      end else tick();
    end
    chk("busy_ign_lat",   lat1, 8);
    chk("busy_ign_res",   int'(r1), int'(RES_EQ));
    chk("busy_ign_nbits", n1, 8);
    start = 1'b1;         // seen by the DONE cycle only
    tick();
    start = 1'b0;
    chk("done_ign_busy", int'(e_busy), 0);
    tick();
    chk("done_ign_idle", int'(e_busy), 0);
    $display("seq ignore: lat=%0d res=%03b nbits=%0d", lat1, r1, n1);
    run_cmp(8'hFF, 8'h00, r1, n1, lat1, cnt1, r0, n0, lat0, cnt0, bb);
    chk("fresh_res",   int'(r1), int'(RES_GT));
    chk("fresh_nbits", n1, 1);
    $display("seq fresh: res=%03b nbits=%0d", r1, n1);

    // Reset during scan cycle 4 of 00 vs 00
    a_in = 8'h00; b_in = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_busy",  int'(e_busy), 0);
    chk("rst_mid_done",  int'(e_done), 0);
    chk("rst_mid_res",   int'({e_aeb, e_agb, e_alb}), 0);
    chk("rst_mid_nbits", int'(e_nbits), 0);
    cnt1 = 0;
    for (int c = 0; c < 12; c++) begin
      if (e_done || f_done) cnt1++;
      tick();
    end
    chk("rst_mid_nodone", cnt1, 0);
    $display("seq reset: stray done pulses=%0d", cnt1);
    run_cmp(8'h00, 8'h00, r1, n1, lat1, cnt1, r0, n0, lat0, cnt0, bb);
    chk("post_rst_res",   int'(r1), int'(RES_EQ));
    chk("post_rst_nbits", n1, 8);
    chk("post_rst_lat",   lat1, 8);

    // start held high with 40 vs 50: k=4, one compare every 6 cycles
    a_in = 8'h40; b_in = 8'h50; start = 1'b1;
    tick();
    pulses = 0; last_done = -1; prev = 0;
    for (int c = 0; c < 26; c++) begin
      if (e_done) begin
        chk($sformatf("b2b%0d_res", pulses),   int'({e_aeb, e_agb, e_alb}), int'(RES_LT));
        chk($sformatf("b2b%0d_nbits", pulses), int'(e_nbits), 4);
        if (pulses == 0) chk("b2b_first", c, 4);
        else             chk($sformatf("b2b%0d_gap", pulses), c - last_done, 6);
        chk($sformatf("b2b%0d_single", pulses), prev, 0);
        $display("seq b2b: done at c=%0d res=%03b nbits=%0d", c, {e_aeb, e_agb, e_alb}, e_nbits);
        pulses++;
        last_done = c;
      end
      prev = int'(e_done);
      tick();
    end
    chk("b2b_count", pulses, 4);
    start = 1'b0;
    for (int c = 0; c < 14; c++) tick();
    chk("final_idle", int'(e_busy | f_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
